// File: rtl/reg_port_arbiter.sv
// Four-requester arbiter driving one shared register-file write port (RegE/RegFunSel/RegI).
// Define REG_ARB_ROUND_ROBIN_EN for round-robin winner selection; otherwise fixed priority, requester 0 highest.
module reg_port_arbiter #(
   parameter int NREG = 4
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic [3:0]      Req,
   input  logic [3:0]      Lock,
   input  logic [11:0]     ReqSel,
   input  logic [11:0]     ReqFunSel,
   input  logic [63:0]     ReqData,
   output logic [3:0]      Ack,
   output logic [NREG-1:0] RegE,
   output logic [2:0]      RegFunSel,
   output logic [15:0]     RegI,
   output logic            SelErr,
   output logic            Busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] NREG_LIM = 4'(NREG);

   state_t          state_reg, state_next;
   logic [1:0]      owner_reg, owner_next;

   logic [1:0]      win;
   logic            win_valid;
   logic            grant;
   logic [1:0]      grant_id;

   logic [2:0]      sel_arr  [4];
   logic [2:0]      fun_arr  [4];
   logic [15:0]     data_arr [4];
   logic [2:0]      grant_sel;
   logic [2:0]      grant_fun;
   logic [15:0]     grant_data;

   logic [3:0]      ack_reg, ack_next;
   logic [NREG-1:0] reg_e_reg, reg_e_next;
   logic [2:0]      fun_reg, fun_next;
   logic [15:0]     data_reg, data_next;
   logic            sel_err_reg, sel_err_next;
   logic            busy_reg, busy_next;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
         assign sel_arr[gi]  = ReqSel[3*gi +: 3];
         assign fun_arr[gi]  = ReqFunSel[3*gi +: 3];
         assign data_arr[gi] = ReqData[16*gi +: 16];
      end
   endgenerate

`ifdef REG_ARB_ROUND_ROBIN_EN
   logic [1:0] ptr_reg, ptr_next;
   logic [1:0] cand;

   // Scan offsets downward so the candidate nearest the pointer is the last one written.
   always_comb begin
      win  = ptr_reg;
      cand = ptr_reg;
      for (int i = 3; i >= 0; i--) begin
         cand = ptr_reg + 2'(i);
         if (Req[cand]) begin
            win = cand;
         end
      end
      win_valid = |Req;
   end

   assign ptr_next = grant ? (grant_id + 2'd1) : ptr_reg;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         ptr_reg <= 2'd0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end
`else
   always_comb begin
      win = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (Req[i]) begin
            win = 2'(i);
         end
      end
      win_valid = |Req;
   end
`endif

   always_comb begin
      state_next = state_reg;
      owner_next = owner_reg;
      grant      = 1'b0;
      grant_id   = owner_reg;
      case (state_reg)
         IDLE: begin
            if (win_valid) begin
               grant      = 1'b1;
               grant_id   = win;
               owner_next = win;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            // Requests are ignored here; only the owner's lock decides where to go.
            state_next = Lock[owner_reg] ? LOCKED : IDLE;
         end
         LOCKED: begin
            if (Req[owner_reg]) begin
               grant      = 1'b1;
               grant_id   = owner_reg;
               state_next = ISSUE;
            end else if (!Lock[owner_reg]) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign grant_sel  = sel_arr[grant_id];
   assign grant_fun  = fun_arr[grant_id];
   assign grant_data = data_arr[grant_id];

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_rege
         assign reg_e_next[gi] = grant && (grant_sel == 3'(gi));
      end
   endgenerate

   // Outputs are computed for the upcoming cycle and registered, so ISSUE sees them directly.
   always_comb begin
      ack_next = 4'b0000;
      if (grant) begin
         ack_next[grant_id] = 1'b1;
      end
      sel_err_next = grant && ({1'b0, grant_sel} >= NREG_LIM);
      fun_next     = grant ? grant_fun  : fun_reg;
      data_next    = grant ? grant_data : data_reg;
      busy_next    = (state_next != IDLE);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_reg   <= IDLE;
         owner_reg   <= 2'd0;
         ack_reg     <= 4'b0000;
         reg_e_reg   <= '0;
         fun_reg     <= 3'b000;
         data_reg    <= 16'h0000;
         sel_err_reg <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         owner_reg   <= owner_next;
         ack_reg     <= ack_next;
         reg_e_reg   <= reg_e_next;
         fun_reg     <= fun_next;
         data_reg    <= data_next;
         sel_err_reg <= sel_err_next;
         busy_reg    <= busy_next;
      end
   end

   assign Ack       = ack_reg;
   assign RegE      = reg_e_reg;
   assign RegFunSel = fun_reg;
   assign RegI      = data_reg;
   assign SelErr    = sel_err_reg;
   assign Busy      = busy_reg;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter: expected issues are queued when driven and checked on Ack.
module tb_reg_port_arbiter;

   logic        Clock;
   logic        Reset;
   logic [3:0]  Req;
   logic [3:0]  Lock;
   logic [11:0] ReqSel;
   logic [11:0] ReqFunSel;
   logic [63:0] ReqData;
   logic [3:0]  Ack;
   logic [3:0]  RegE;
   logic [2:0]  RegFunSel;
   logic [15:0] RegI;
   logic        SelErr;
   logic        Busy;

   typedef struct packed {
      logic [3:0]  ack;
      logic [3:0]  rege;
      logic [2:0]  fun;
      logic [15:0] data;
      logic        selerr;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   reg_port_arbiter #(.NREG(4)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Req       (Req),
      .Lock      (Lock),
      .ReqSel    (ReqSel),
      .ReqFunSel (ReqFunSel),
      .ReqData   (ReqData),
      .Ack       (Ack),
      .RegE      (RegE),
      .RegFunSel (RegFunSel),
      .RegI      (RegI),
      .SelErr    (SelErr),
      .Busy      (Busy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [3:0] r, input logic [2:0] f,
                       input logic [15:0] d, input logic s);
      exp_t e;
      e.ack    = a;
      e.rege   = r;
      e.fun    = f;
      e.data   = d;
      e.selerr = s;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input int k, input logic [2:0] s, input logic [2:0] f, input logic [15:0] d);
      ReqSel[3*k +: 3]     = s;
      ReqFunSel[3*k +: 3]  = f;
      ReqData[16*k +: 16]  = d;
   endtask

   // Any cycle with an Ack must match the oldest queued issue; otherwise the port must be quiet.
   task automatic monitor();
      exp_t e;
      if (Ack !== 4'b0000) begin
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_ack observed=%b expected=none", Ack);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            $display("cycle %0d issue ack=%b rege=%b fun=%b data=%h selerr=%b",
                     cyc, Ack, RegE, RegFunSel, RegI, SelErr);
            chk("ack", Ack, e.ack);
            chk("rege", RegE, e.rege);
            chk("regfunsel", RegFunSel, e.fun);
            chk("regi", RegI, e.data);
            chk("selerr", SelErr, e.selerr);
         end
      end else begin
         chk("quiet_rege", RegE, 0);
         chk("quiet_selerr", SelErr, 0);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      cyc++;
      @(negedge Clock);
      monitor();
   endtask

   task automatic wait_ack();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         if (Ack !== 4'b0000) seen = 1'b1;
      end
      n_assert++;
      assert (seen) else begin
         n_fail++;
         $error("FAIL ack_timeout observed=no_ack expected=ack_within_8_cycles");
      end
   endtask

   initial begin
      int t0;
      int prev;
      int order [4];

      Reset = 1'b1; Req = 4'b0000; Lock = 4'b0000;
      ReqSel = '0; ReqFunSel = '0; ReqData = '0;
      tick(); tick();
      chk("rst_ack", Ack, 0);
      chk("rst_rege", RegE, 0);
      chk("rst_fun", RegFunSel, 0);
      chk("rst_data", RegI, 0);
      chk("rst_selerr", SelErr, 0);
      chk("rst_busy", Busy, 0);
      Reset = 1'b0;

      // Single grant to requester 1, one-cycle latency, then back to IDLE.
      set_req(1, 3'd2, 3'b010, 16'hABCD);
      Req = 4'b0010;
      push(4'b0010, 4'b0100, 3'b010, 16'hABCD, 1'b0);
      t0 = cyc;
      wait_ack();
      chk("latency", 16'(cyc - t0), 1);
      chk("busy_issue", Busy, 1);
      Req = 4'b0000;
      tick();
      chk("busy_idle", Busy, 0);
      chk("hold_fun", RegFunSel, 3'b010);
      chk("hold_data", RegI, 16'hABCD);
      tick();

      // All four request, each drops after its Ack: order 0..3, one issue per two cycles.
      Reset = 1'b1; tick(); Reset = 1'b0;
      for (int k = 0; k < 4; k++) set_req(k, 3'(k), 3'(k + 1), 16'hA000 + 16'(k));
      Req = 4'b1111;
      for (int k = 0; k < 4; k++) push(4'b0001 << k, 4'b0001 << k, 3'(k + 1), 16'hA000 + 16'(k), 1'b0);
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_ack();
         if (i > 0) chk("issue_gap", 16'(cyc - prev), 2);
         prev = cyc;
         Req[i] = 1'b0;
      end
      tick();

      // Requester 0 keeps requesting.
`ifdef REG_ARB_ROUND_ROBIN_EN
      order = '{0, 1, 2, 3};
`else
      order = '{0, 0, 0, 0};
`endif
      Req = 4'b1111;
      for (int i = 0; i < 4; i++)
         push(4'b0001 << order[i], 4'b0001 << order[i], 3'(order[i] + 1), 16'hA000 + 16'(order[i]), 1'b0);
      for (int i = 0; i < 4; i++) begin
         wait_ack();
         if (order[i] != 0) Req[order[i]] = 1'b0;
      end
      Req = 4'b0000;
      tick(); tick();

      // Locked requester 2 issues twice back to back; requester 0 waits for the unlock.
      set_req(2, 3'd0, 3'b011, 16'h2222);
      set_req(0, 3'd3, 3'b001, 16'h0F0F);
      Lock = 4'b0100;
      Req  = 4'b0100;
      push(4'b0100, 4'b0001, 3'b011, 16'h2222, 1'b0);
      wait_ack();
      prev = cyc;
      set_req(2, 3'd1, 3'b011, 16'h3333);
      Req = 4'b0101;
      push(4'b0100, 4'b0010, 3'b011, 16'h3333, 1'b0);
      wait_ack();
      chk("lock_gap", 16'(cyc - prev), 2);
      Req = 4'b0001;
      tick();
      chk("busy_locked1", Busy, 1);
      tick();
      chk("busy_locked2", Busy, 1);
      Lock = 4'b0000;
      prev = cyc;
      push(4'b0001, 4'b1000, 3'b001, 16'h0F0F, 1'b0);
      wait_ack();
      chk("unlock_latency", 16'(cyc - prev), 2);
      Req = 4'b0000;
      tick();

      // Out-of-range indices are dropped with SelErr; index NREG-1 is the last valid one.
      set_req(1, 3'd5, 3'b100, 16'h5555);
      Req = 4'b0010;
      push(4'b0010, 4'b0000, 3'b100, 16'h5555, 1'b1);
      wait_ack();
      Req = 4'b0000;
      tick();
      set_req(3, 3'd4, 3'b110, 16'h4444);
      Req = 4'b1000;
      push(4'b1000, 4'b0000, 3'b110, 16'h4444, 1'b1);
      wait_ack();
      Req = 4'b0000;
      tick();
      set_req(3, 3'd3, 3'b111, 16'h7777);
      Req = 4'b1000;
      push(4'b1000, 4'b1000, 3'b111, 16'h7777, 1'b0);
      wait_ack();
      Req = 4'b0000;
      tick();

      // Reset on a grant edge: no issue, and the pointer restarts at 0.
      set_req(1, 3'd1, 3'b101, 16'h1111);
      Req = 4'b0010;
      push(4'b0010, 4'b0010, 3'b101, 16'h1111, 1'b0);
      wait_ack();
      Req = 4'b0000;
      tick();
      Req   = 4'b0100;
      Reset = 1'b1;
      tick();
      chk("rstgrant_ack", Ack, 0);
      chk("rstgrant_rege", RegE, 0);
      chk("rstgrant_busy", Busy, 0);
      chk("rstgrant_fun", RegFunSel, 0);
      chk("rstgrant_data", RegI, 0);
      Reset = 1'b0;
      for (int k = 0; k < 4; k++) set_req(k, 3'(k), 3'(k + 1), 16'hA000 + 16'(k));
      Req = 4'b1111;
      push(4'b0001, 4'b0001, 3'b001, 16'hA000, 1'b0);
      wait_ack();
      Req = 4'b0000;
      tick(); tick();

      chk("queue_empty", 16'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_port_arbiter.md
REG_PORT_ARBITER -- requirements
Module: reg_port_arbiter

Interface
REQ-001 The block SHALL have parameter NREG, default 4, giving the number of target 16-bit registers (legal 1..8).
REQ-002 The block SHALL have port Clock, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port Reset, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port Req, input, 4, one request bit per requester 0..3.
REQ-005 The block SHALL have port Lock, input, 4, per-requester bit to keep ownership after its grant.
REQ-006 The block SHALL have port ReqSel, input, 12, 3-bit target register index per requester (requester k at bits 3k+2:3k).
REQ-007 The block SHALL have port ReqFunSel, input, 12, 3-bit register FunSel code per requester (same packing).
REQ-008 The block SHALL have port ReqData, input, 64, 16-bit operand per requester (requester k at bits 16k+15:16k).
REQ-009 The block SHALL have port Ack, output, 4, one-cycle pulse to the requester whose operation is issued.
REQ-010 The block SHALL have port RegE, output, NREG, one-hot enable to the register file.
REQ-011 The block SHALL have port RegFunSel, output, 3, FunSel driven to all registers.
REQ-012 The block SHALL have port RegI, output, 16, data driven to all register I inputs.
REQ-013 The block SHALL have port SelErr, output, 1, one-cycle pulse when an issued index is >= NREG.
REQ-014 The block SHALL have port Busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 The block SHALL implement states IDLE, ISSUE, LOCKED; all outputs registered.
REQ-016 IDLE: at an edge with Req != 0, winner w SHALL be chosen, its ReqSel/ReqFunSel/ReqData captured, state -> ISSUE.
REQ-017 ISSUE (exactly one cycle): RegE bit Sel = 1 if Sel < NREG, RegFunSel and RegI = captured values, Ack[w] = 1, all other Ack bits 0.
REQ-018 ISSUE with Sel >= NREG: RegE SHALL be all-zero, SelErr = 1, Ack[w] still 1 (operation dropped).
REQ-019 At the edge ending ISSUE, Req SHALL be ignored; next state = LOCKED if Lock[w] = 1 at that edge, else IDLE.
REQ-020 LOCKED: Req[w] = 1 SHALL recapture w's fields, state -> ISSUE; Lock[w] = 0 SHALL return to IDLE; other requesters wait.
REQ-021 Outside ISSUE, RegE, Ack and SelErr SHALL be 0; RegFunSel and RegI hold their last values.
REQ-022 Issue rate SHALL be at most one operation per two cycles; latency Req rise (sampled in IDLE) to Ack = 1 cycle.
REQ-023 A requester SHALL hold Req and its fields stable until Ack; changing them earlier is undefined.
REQ-024 Round-robin pointer SHALL be set to (w+1) mod 4 at every grant; ties resolved by searching upward from the pointer with wrap.

Reset
REQ-025 Reset sampled high SHALL force state IDLE, pointer 0, Ack 0, RegE 0, SelErr 0, Busy 0, RegFunSel 3'b000, RegI 0 at that edge.
REQ-026 Reset during ISSUE SHALL suppress that operation's Ack and RegE in the next cycle; the requester re-requests.
REQ-027 Reset SHALL take priority over every request and lock.

Configuration
REQ-028 Macro REG_ARB_ROUND_ROBIN_EN defined: winner selection per REQ-024.
REQ-029 Macro REG_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 highest, 3 lowest; pointer logic absent; all other behaviour unchanged.

Verification
REQ-030 Reset, then Req=4'b0010, Sel1=2, FunSel1=3'b010, Data1=16'hABCD -> next cycle RegE=4'b0100, RegFunSel=010, RegI=ABCD, Ack=0010, then IDLE.
REQ-031 Req=4'b1111 held, each dropped after its Ack (round-robin build) -> Ack order 0,1,2,3, one Ack every 2 cycles.
REQ-032 Same stimulus without REG_ARB_ROUND_ROBIN_EN, requester 0 re-requesting immediately -> requester 0 granted every slot, others starved.
REQ-033 Requester 2 with Lock[2]=1, Req=4'b0101 continuously, ops to Sel 0 then 1 -> two consecutive Acks to requester 2 via LOCKED; requester 0 granted only after Lock[2]=0.
REQ-034 Sel=5 with NREG=4 -> RegE=0000, SelErr=1, Ack pulsed, register contents unchanged.
REQ-035 Reset asserted in the ISSUE-entry cycle of a grant -> no Ack, RegE=0 next cycle, Busy=0, pointer=0.
